// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP transmit segment engine.
package tcp_pkg;

  localparam int FLOWID_W         = 4;
  localparam int TX_PAYLOAD_PTR_W = 16;
  localparam int PTR_FULL_W       = TX_PAYLOAD_PTR_W + 1;
  localparam int IP_ADDR_W        = 32;
  localparam int TX_MSS_DEFAULT   = 1460;

  localparam logic [7:0] TCP_FLAG_FIN = 8'h01;
  localparam logic [7:0] TCP_FLAG_SYN = 8'h02;
  localparam logic [7:0] TCP_FLAG_RST = 8'h04;
  localparam logic [7:0] TCP_FLAG_PSH = 8'h08;
  localparam logic [7:0] TCP_FLAG_ACK = 8'h10;

  // Read channel indices into the per-channel issued/received vectors.
  localparam int CH_TX    = 0;
  localparam int CH_RX    = 1;
  localparam int CH_HEAD  = 2;
  localparam int CH_TAIL  = 3;
  localparam int CH_TUPLE = 4;
  localparam int NUM_CH   = 5;

  typedef enum logic [1:0] {
    TX_SEG_IDLE  = 2'd0,
    TX_SEG_FETCH = 2'd1,
    TX_SEG_CALC  = 2'd2,
    TX_SEG_EMIT  = 2'd3
  } tx_seg_state_e;

  typedef struct packed {
    logic [31:0]           our_seq;
    logic [PTR_FULL_W-1:0] unsent_ptr;
    logic [15:0]           their_win;
  } smol_tx_state_struct;

  typedef struct packed {
    logic [31:0] ack_num;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [IP_ADDR_W-1:0] host_ip;
    logic [IP_ADDR_W-1:0] dest_ip;
    logic [15:0]          host_port;
    logic [15:0]          dest_port;
  } four_tuple_struct;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] win_size;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [TX_PAYLOAD_PTR_W-1:0] addr;
    logic [PTR_FULL_W-1:0]       size;
  } smol_payload_buf_struct;

  typedef struct packed {
    logic [PTR_FULL_W-1:0] len;
    logic                  has_data;
  } tx_seg_calc_struct;

  localparam int SMOL_TX_STATE_STRUCT_W = $bits(smol_tx_state_struct);

  function automatic logic [PTR_FULL_W-1:0] ptr_min(input logic [PTR_FULL_W-1:0] a,
                                                    input logic [PTR_FULL_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tcp_tx_seg_datap.sv
// Datapath for the tx segment engine: response latches, segment sizing, header and writeback build.
module tcp_tx_seg_datap
  import tcp_pkg::*;
#(
  parameter int          TX_MSS  = TX_MSS_DEFAULT,
  parameter logic [15:0] ADV_WIN = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_fire,
  input  logic [FLOWID_W-1:0]    cmd_flowid,
  input  logic                   cmd_force_ack,
  input  logic                   calc_en,
  input  logic [NUM_CH-1:0]      resp_fire,
  input  smol_tx_state_struct    tx_state_resp,
  input  smol_rx_state_struct    rx_state_resp,
  input  logic [PTR_FULL_W-1:0]  head_resp,
  input  logic [PTR_FULL_W-1:0]  tail_resp,
  input  four_tuple_struct       tuple_resp,
  output logic [FLOWID_W-1:0]    flowid,
  output logic                   force_ack,
  output tx_seg_calc_struct      calc,
  output tcp_pkt_hdr             pkt_hdr,
  output logic [IP_ADDR_W-1:0]   src_ip,
  output logic [IP_ADDR_W-1:0]   dst_ip,
  output smol_payload_buf_struct payload_entry,
  output smol_tx_state_struct    wb_data
);

  localparam logic [PTR_FULL_W-1:0] MSS_PTR = PTR_FULL_W'(TX_MSS);

  smol_tx_state_struct   tx_st_r;
  smol_rx_state_struct   rx_st_r;
  logic [PTR_FULL_W-1:0] head_r;
  logic [PTR_FULL_W-1:0] tail_r;
  four_tuple_struct      tuple_r;

  logic [PTR_FULL_W-1:0] avail;
  logic [PTR_FULL_W-1:0] inflight;
  logic [PTR_FULL_W-1:0] win_ext;
  logic [PTR_FULL_W-1:0] win_left;
  logic [PTR_FULL_W-1:0] len_nxt;
  tx_seg_calc_struct     calc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      flowid    <= '0;
      force_ack <= 1'b0;
      tx_st_r   <= '0;
      rx_st_r   <= '0;
      head_r    <= '0;
      tail_r    <= '0;
      tuple_r   <= '0;
      calc      <= '0;
    end else begin
      if (cmd_fire) begin
        flowid    <= cmd_flowid;
        force_ack <= cmd_force_ack;
      end
      if (resp_fire[CH_TX])    tx_st_r <= tx_state_resp;
      if (resp_fire[CH_RX])    rx_st_r <= rx_state_resp;
      if (resp_fire[CH_HEAD])  head_r  <= head_resp;
      if (resp_fire[CH_TAIL])  tail_r  <= tail_resp;
      if (resp_fire[CH_TUPLE]) tuple_r <= tuple_resp;
      if (calc_en)             calc    <= calc_nxt;
    end
  end

  // Pointers carry one extra wrap bit, so plain modular subtraction gives distances.
  always_comb begin
    avail    = tail_r - tx_st_r.unsent_ptr;
    inflight = tx_st_r.unsent_ptr - head_r;
    win_ext  = PTR_FULL_W'(tx_st_r.their_win);
    win_left = (win_ext > inflight) ? (win_ext - inflight) : '0;
    len_nxt  = ptr_min(ptr_min(avail, MSS_PTR), win_left);
    calc_nxt          = '0;
    calc_nxt.len      = len_nxt;
    calc_nxt.has_data = (len_nxt != '0);
  end

  always_comb begin
    pkt_hdr          = '0;
    pkt_hdr.src_port = tuple_r.host_port;
    pkt_hdr.dst_port = tuple_r.dest_port;
    pkt_hdr.seq_num  = tx_st_r.our_seq;
    pkt_hdr.ack_num  = rx_st_r.ack_num;
    pkt_hdr.flags    = calc.has_data ? (TCP_FLAG_ACK | TCP_FLAG_PSH) : TCP_FLAG_ACK;
    pkt_hdr.win_size = ADV_WIN;

    src_ip = tuple_r.host_ip;
    dst_ip = tuple_r.dest_ip;

    payload_entry      = '0;
    payload_entry.addr = tx_st_r.unsent_ptr[TX_PAYLOAD_PTR_W-1:0];
    payload_entry.size = calc.len;

    wb_data            = tx_st_r;
    wb_data.our_seq    = tx_st_r.our_seq + 32'(calc.len);
    wb_data.unsent_ptr = tx_st_r.unsent_ptr + calc.len;
  end

endmodule

// File: rtl/tcp_tx_seg_engine.sv
// Transmit segment engine: FSM and handshake control around tcp_tx_seg_datap.
// state | meaning
// IDLE  | waiting for a scheduler command
// FETCH | five state reads outstanding, any response order
// CALC  | registering segment length
// EMIT  | enqueue header/payload and write back tx state, each until handshaken
module tcp_tx_seg_engine
  import tcp_pkg::*;
#(
  parameter int          TX_MSS  = TX_MSS_DEFAULT,
  parameter logic [15:0] ADV_WIN = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   sched_tx_cmd_val,
  output logic                   sched_tx_cmd_rdy,
  input  logic [FLOWID_W-1:0]    sched_tx_cmd_flowid,
  input  logic                   sched_tx_cmd_force_ack,

  output logic                   tx_state_rd_req_val,
  input  logic                   tx_state_rd_req_rdy,
  output logic [FLOWID_W-1:0]    tx_state_rd_req_addr,
  input  logic                   tx_state_rd_resp_val,
  output logic                   tx_state_rd_resp_rdy,
  input  smol_tx_state_struct    tx_state_rd_resp_data,

  output logic                   rx_state_rd_req_val,
  input  logic                   rx_state_rd_req_rdy,
  output logic [FLOWID_W-1:0]    rx_state_rd_req_addr,
  input  logic                   rx_state_rd_resp_val,
  output logic                   rx_state_rd_resp_rdy,
  input  smol_rx_state_struct    rx_state_rd_resp_data,

  output logic                   tx_head_ptr_rd_req_val,
  input  logic                   tx_head_ptr_rd_req_rdy,
  output logic [FLOWID_W-1:0]    tx_head_ptr_rd_req_addr,
  input  logic                   tx_head_ptr_rd_resp_val,
  output logic                   tx_head_ptr_rd_resp_rdy,
  input  logic [PTR_FULL_W-1:0]  tx_head_ptr_rd_resp_data,

  output logic                   tx_tail_ptr_rd_req_val,
  input  logic                   tx_tail_ptr_rd_req_rdy,
  output logic [FLOWID_W-1:0]    tx_tail_ptr_rd_req_addr,
  input  logic                   tx_tail_ptr_rd_resp_val,
  output logic                   tx_tail_ptr_rd_resp_rdy,
  input  logic [PTR_FULL_W-1:0]  tx_tail_ptr_rd_resp_data,

  output logic                   tuple_rd_req_val,
  input  logic                   tuple_rd_req_rdy,
  output logic [FLOWID_W-1:0]    tuple_rd_req_addr,
  input  logic                   tuple_rd_resp_val,
  output logic                   tuple_rd_resp_rdy,
  input  four_tuple_struct       tuple_rd_resp_data,

  output logic                   tx_state_wr_req_val,
  input  logic                   tx_state_wr_req_rdy,
  output logic [FLOWID_W-1:0]    tx_state_wr_req_addr,
  output smol_tx_state_struct    tx_state_wr_req_data,

  output logic                   tx_send_pkt_enq_req_val,
  input  logic                   tx_send_pkt_enq_req_rdy,
  output logic [FLOWID_W-1:0]    tx_send_pkt_enq_flowid,
  output tcp_pkt_hdr             tx_send_pkt_enq_pkt,
  output logic [IP_ADDR_W-1:0]   tx_send_pkt_enq_src_ip,
  output logic [IP_ADDR_W-1:0]   tx_send_pkt_enq_dst_ip,
  output smol_payload_buf_struct tx_send_pkt_enq_payload_entry
);

  tx_seg_state_e     state_r, state_nxt;
  logic [NUM_CH-1:0] issued_r, got_r;
  logic [NUM_CH-1:0] req_val, req_rdy, resp_val, resp_rdy;
  logic [NUM_CH-1:0] req_fire, resp_fire;
  logic              enq_done_r, wb_done_r;
  logic              cmd_fire, enq_fire, wb_fire;
  logic              send, has_data, enq_ok, wb_ok;
  logic              in_fetch;

  logic [FLOWID_W-1:0] flowid;
  logic                force_ack;
  tx_seg_calc_struct   calc;

  assign req_rdy  = {tuple_rd_req_rdy, tx_tail_ptr_rd_req_rdy, tx_head_ptr_rd_req_rdy,
                     rx_state_rd_req_rdy, tx_state_rd_req_rdy};
  assign resp_val = {tuple_rd_resp_val, tx_tail_ptr_rd_resp_val, tx_head_ptr_rd_resp_val,
                     rx_state_rd_resp_val, tx_state_rd_resp_val};

  assign in_fetch  = (state_r == TX_SEG_FETCH);
  assign req_val   = {NUM_CH{in_fetch}} & ~issued_r;
  assign resp_rdy  = {NUM_CH{in_fetch}} & ~got_r;
  assign req_fire  = req_val & req_rdy;
  assign resp_fire = resp_val & resp_rdy;

  assign {tuple_rd_req_val, tx_tail_ptr_rd_req_val, tx_head_ptr_rd_req_val,
          rx_state_rd_req_val, tx_state_rd_req_val} = req_val;
  assign {tuple_rd_resp_rdy, tx_tail_ptr_rd_resp_rdy, tx_head_ptr_rd_resp_rdy,
          rx_state_rd_resp_rdy, tx_state_rd_resp_rdy} = resp_rdy;

  assign tx_state_rd_req_addr    = flowid;
  assign rx_state_rd_req_addr    = flowid;
  assign tx_head_ptr_rd_req_addr = flowid;
  assign tx_tail_ptr_rd_req_addr = flowid;
  assign tuple_rd_req_addr       = flowid;
  assign tx_state_wr_req_addr    = flowid;
  assign tx_send_pkt_enq_flowid  = flowid;

  assign has_data = calc.has_data;
  assign send     = calc.has_data | force_ack;
  assign cmd_fire = sched_tx_cmd_val & sched_tx_cmd_rdy;
  assign enq_fire = tx_send_pkt_enq_req_val & tx_send_pkt_enq_req_rdy;
  assign wb_fire  = tx_state_wr_req_val & tx_state_wr_req_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= TX_SEG_IDLE;
      issued_r   <= '0;
      got_r      <= '0;
      enq_done_r <= 1'b0;
      wb_done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (cmd_fire) begin
        issued_r   <= '0;
        got_r      <= '0;
        enq_done_r <= 1'b0;
        wb_done_r  <= 1'b0;
      end else begin
        issued_r <= issued_r | req_fire;
        got_r    <= got_r | resp_fire;
        if (enq_fire) enq_done_r <= 1'b1;
        if (wb_fire)  wb_done_r  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt               = state_r;
    sched_tx_cmd_rdy        = 1'b0;
    tx_send_pkt_enq_req_val = 1'b0;
    tx_state_wr_req_val     = 1'b0;
    enq_ok                  = 1'b0;
    wb_ok                   = 1'b0;
    case (state_r)
      TX_SEG_IDLE: begin
        sched_tx_cmd_rdy = ~rst;
        if (sched_tx_cmd_val && !rst) state_nxt = TX_SEG_FETCH;
      end
      TX_SEG_FETCH: begin
        if (&(got_r | resp_fire)) state_nxt = TX_SEG_CALC;
      end
      TX_SEG_CALC: begin
        state_nxt = TX_SEG_EMIT;
      end
      TX_SEG_EMIT: begin
        tx_send_pkt_enq_req_val = send & ~enq_done_r;
        tx_state_wr_req_val     = has_data & ~wb_done_r;
        enq_ok = ~send | enq_done_r | enq_fire;
        wb_ok  = ~has_data | wb_done_r | wb_fire;
        if (enq_ok && wb_ok) state_nxt = TX_SEG_IDLE;
      end
      default: state_nxt = TX_SEG_IDLE;
    endcase
  end

  tcp_tx_seg_datap #(
    .TX_MSS  (TX_MSS),
    .ADV_WIN (ADV_WIN)
  ) u_datap (
    .clk           (clk),
    .rst           (rst),
    .cmd_fire      (cmd_fire),
    .cmd_flowid    (sched_tx_cmd_flowid),
    .cmd_force_ack (sched_tx_cmd_force_ack),
    .calc_en       (state_r == TX_SEG_CALC),
    .resp_fire     (resp_fire),
    .tx_state_resp (tx_state_rd_resp_data),
    .rx_state_resp (rx_state_rd_resp_data),
    .head_resp     (tx_head_ptr_rd_resp_data),
    .tail_resp     (tx_tail_ptr_rd_resp_data),
    .tuple_resp    (tuple_rd_resp_data),
    .flowid        (flowid),
    .force_ack     (force_ack),
    .calc          (calc),
    .pkt_hdr       (tx_send_pkt_enq_pkt),
    .src_ip        (tx_send_pkt_enq_src_ip),
    .dst_ip        (tx_send_pkt_enq_dst_ip),
    .payload_entry (tx_send_pkt_enq_payload_entry),
    .wb_data       (tx_state_wr_req_data)
  );

endmodule
